// File: rtl/bht_ctrl_pkg.sv
// rtl/bht_ctrl_pkg.sv - shared FSM state and update-entry types for the BHT update controller
package bht_ctrl_pkg;

  localparam int BHT_VLEN       = 64;
  localparam int BHT_INDEX_BITS = 6;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_IDLE  = 2'd2
  } bht_state_e;

  typedef struct packed {
    logic [BHT_VLEN-1:0]       pc;
    logic                      taken;
    logic [BHT_INDEX_BITS-1:0] index;
  } bht_upd_entry_t;

endpackage

// File: rtl/bht_update_ctrl_if.sv
// rtl/bht_update_ctrl_if.sv - requester, BHT update and row-initialise signal bundle
interface bht_update_ctrl_if #(
  parameter int NUM_REQ    = 2,
  parameter int VLEN       = 64,
  parameter int INDEX_BITS = 6,
  parameter int NR_ROWS    = 64
);
  localparam int ROW_W = (NR_ROWS > 1) ? $clog2(NR_ROWS) : 1;

  logic                                flush_i;
  logic                                debug_mode_i;
  logic [NUM_REQ-1:0]                  req_valid_i;
  logic [NUM_REQ-1:0]                  req_ready_o;
  logic [NUM_REQ-1:0][VLEN-1:0]        req_pc_i;
  logic [NUM_REQ-1:0]                  req_taken_i;
  logic [NUM_REQ-1:0][INDEX_BITS-1:0]  req_index_i;
  logic                                upd_valid_o;
  logic [VLEN-1:0]                     upd_pc_o;
  logic                                upd_taken_o;
  logic [INDEX_BITS-1:0]               upd_index_o;
  logic                                init_we_o;
  logic [ROW_W-1:0]                    init_row_o;
  logic                                flush_done_o;
  logic                                busy_o;

  modport slave (
    input  flush_i, debug_mode_i, req_valid_i, req_pc_i, req_taken_i, req_index_i,
    output req_ready_o, upd_valid_o, upd_pc_o, upd_taken_o, upd_index_o,
           init_we_o, init_row_o, flush_done_o, busy_o
  );

  modport master (
    output flush_i, debug_mode_i, req_valid_i, req_pc_i, req_taken_i, req_index_i,
    input  req_ready_o, upd_valid_o, upd_pc_o, upd_taken_o, upd_index_o,
           init_we_o, init_row_o, flush_done_o, busy_o
  );

endinterface

// File: rtl/bht_upd_fifo.sv
// rtl/bht_upd_fifo.sv - power-of-2 update buffer with wrapping pointers and occupancy counter
module bht_upd_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // simultaneous push and pop leaves occupancy unchanged
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // payload storage needs no reset: head is only consumed while count is non-zero
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// rtl/bht_update_ctrl.sv - BHT row init sequencer plus round-robin update buffer
// Optional counters: define BHT_UPD_CTRL_STATS_EN for stat_accepted_o / stat_dropped_o.
module bht_update_ctrl
  import bht_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int NR_ROWS    = 64,
  parameter int VLEN       = BHT_VLEN,
  parameter int INDEX_BITS = BHT_INDEX_BITS
) (
  input  logic clk_i,
  input  logic rst_i,
  bht_update_ctrl_if.slave bus
`ifdef BHT_UPD_CTRL_STATS_EN
  ,
  output logic [31:0] stat_accepted_o,
  output logic [31:0] stat_dropped_o
`endif
);

  localparam int ROW_W = (NR_ROWS > 1) ? $clog2(NR_ROWS) : 1;
  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  bht_state_e            state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [REQ_W-1:0]      rr_q, grant_idx, cand_idx;
  logic                  done_q, done_d;
  logic                  found, accept_ok, hs, push, pop, upd_valid;
  logic                  fifo_clr, fifo_empty, fifo_full;
  logic [NUM_REQ-1:0]    grant_oh;
  logic [VLEN-1:0]       sel_pc;
  logic [INDEX_BITS-1:0] sel_index;
  bht_upd_entry_t        push_entry, head;
  int                    cand;

  // first valid requester at or after rr_q wins
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(rr_q) + k) % NUM_REQ;
      cand_idx = REQ_W'(cand);
      if (!found && bus.req_valid_i[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (found) grant_oh[grant_idx] = 1'b1;
  end

  assign accept_ok = (state_q == ST_IDLE) && !fifo_full && !bus.flush_i;
  assign hs        = found && accept_ok;
  assign push      = hs && !bus.debug_mode_i;

  assign sel_pc     = bus.req_pc_i[grant_idx];
  assign sel_index  = bus.req_index_i[grant_idx];
  assign push_entry = '{pc: sel_pc, taken: bus.req_taken_i[grant_idx], index: sel_index};

  // a flush request suppresses the head so discarded entries never reach the BHT
  assign upd_valid = (state_q == ST_IDLE) && !fifo_empty && !bus.flush_i;
  assign pop       = upd_valid;
  assign fifo_clr  = (state_q == ST_RST) || ((state_q == ST_IDLE) && bus.flush_i);

  bht_upd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (bht_upd_entry_t)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clr       (fifo_clr),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_RST: begin
        state_d = ST_FLUSH;
        row_d   = '0;
      end
      ST_FLUSH: begin
        if (bus.flush_i) begin
          row_d = '0;
        end else if (row_q == ROW_W'(NR_ROWS - 1)) begin
          state_d = ST_IDLE;
          row_d   = '0;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.flush_i) begin
          state_d = ST_FLUSH;
          row_d   = '0;
        end
      end
      default: begin
        state_d = ST_RST;
        row_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RST;
      row_q   <= '0;
      rr_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      done_q  <= done_d;
      if (hs) rr_q <= (grant_idx == REQ_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign bus.req_ready_o  = accept_ok ? grant_oh : '0;
  assign bus.upd_valid_o  = upd_valid;
  assign bus.upd_pc_o     = upd_valid ? head.pc    : '0;
  assign bus.upd_taken_o  = upd_valid ? head.taken : 1'b0;
  assign bus.upd_index_o  = upd_valid ? head.index : '0;
  assign bus.init_we_o    = (state_q == ST_FLUSH);
  assign bus.init_row_o   = row_q;
  assign bus.flush_done_o = done_q;
  // reset state is RST, so busy is masked while rst_i holds the block
  assign bus.busy_o       = !rst_i && ((state_q != ST_IDLE) || !fifo_empty);

`ifdef BHT_UPD_CTRL_STATS_EN
  logic        drop;
  logic [31:0] acc_q, drop_q;

  assign drop = hs && bus.debug_mode_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push && (acc_q != '1))  acc_q  <= acc_q + 1'b1;
      if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  assign stat_accepted_o = acc_q;
  assign stat_dropped_o  = drop_q;
`endif

endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb/tb_bht_update_ctrl.sv - directed and random bench for bht_update_ctrl against a queue model
module tb_bht_update_ctrl;

  localparam int NUM_REQ    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int NR_ROWS    = 64;
  localparam int VLEN       = 64;
  localparam int INDEX_BITS = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bht_update_ctrl_if #(
    .NUM_REQ(NUM_REQ), .VLEN(VLEN), .INDEX_BITS(INDEX_BITS), .NR_ROWS(NR_ROWS)
  ) bus ();

`ifdef BHT_UPD_CTRL_STATS_EN
  logic [31:0] stat_acc, stat_drop;
`endif

  bht_update_ctrl #(
    .NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH), .NR_ROWS(NR_ROWS),
    .VLEN(VLEN), .INDEX_BITS(INDEX_BITS)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef BHT_UPD_CTRL_STATS_EN
    ,
    .stat_accepted_o (stat_acc),
    .stat_dropped_o  (stat_drop)
`endif
  );

  typedef struct {
    logic [63:0] pc;
    logic        taken;
    logic [5:0]  index;
  } upd_t;

  upd_t exp_q[$];
  int   m_phase;   // 0: first cycle after reset, 1: writing rows, 2: idle
  int   m_row, m_rr, m_accepted, m_dropped;
  bit   m_done;
  int   e_grant;
  bit   e_hs, e_pop;
  int   checks, errors;
  int   we_cycles, upd_cycles, done_pulses, ready_in_flush;
  logic [1:0] obs_ready;
  logic [5:0] obs_row;
  logic       obs_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_phase = 0; m_row = 0; m_rr = 0; m_done = 0;
    m_accepted = 0; m_dropped = 0;
  endtask

  task automatic check_outputs();
    bit         idle;
    logic [1:0] e_ready;
    logic [63:0] e_pc;
    logic       e_taken;
    logic [5:0] e_index;
    obs_ready = bus.req_ready_o; obs_row = bus.init_row_o; obs_we = bus.init_we_o;
    if (bus.init_we_o) begin
      we_cycles++;
      if (bus.req_ready_o != 2'b00) ready_in_flush++;
    end
    if (bus.upd_valid_o) upd_cycles++;
    if (bus.flush_done_o) done_pulses++;
    e_grant = -1; e_ready = 2'b00; e_hs = 0; e_pop = 0;
    if (rst) begin
      idle = 0;
    end else begin
      idle = (m_phase == 2);
      for (int k = 0; k < NUM_REQ; k++) begin
        int c;
        logic [0:0] cs;
        c = (m_rr + k) % NUM_REQ;
        cs = c[0];
        if (e_grant < 0 && bus.req_valid_i[cs]) e_grant = c;
      end
      if (idle && !bus.flush_i && exp_q.size() < FIFO_DEPTH && e_grant >= 0) e_ready[e_grant[0]] = 1'b1;
      e_hs  = (e_ready != 2'b00);
      e_pop = idle && !bus.flush_i && exp_q.size() > 0;
    end
    e_pc = '0; e_taken = 1'b0; e_index = '0;
    if (e_pop) begin e_pc = exp_q[0].pc; e_taken = exp_q[0].taken; e_index = exp_q[0].index; end
    chk("req_ready", 64'(bus.req_ready_o), 64'(e_ready));
    chk("upd_valid", 64'(bus.upd_valid_o), 64'(e_pop));
    chk("upd_pc", bus.upd_pc_o, e_pc);
    chk("upd_taken", 64'(bus.upd_taken_o), 64'(e_taken));
    chk("upd_index", 64'(bus.upd_index_o), 64'(e_index));
    chk("init_we", 64'(bus.init_we_o), 64'(!rst && m_phase == 1));
    chk("init_row", 64'(bus.init_row_o), (!rst && m_phase == 1) ? 64'(m_row) : 64'd0);
    chk("flush_done", 64'(bus.flush_done_o), 64'(!rst && m_done));
    chk("busy", 64'(bus.busy_o), 64'(!rst && !(idle && exp_q.size() == 0)));
`ifdef BHT_UPD_CTRL_STATS_EN
    chk("stat_accepted", 64'(stat_acc), rst ? 64'd0 : 64'(m_accepted));
    chk("stat_dropped", 64'(stat_drop), rst ? 64'd0 : 64'(m_dropped));
`endif
  endtask

  task automatic model_update();
    upd_t e;
    logic [0:0] g;
    if (rst) begin model_reset(); return; end
    if (e_pop) void'(exp_q.pop_front());
    if (e_hs) begin
      g = e_grant[0];
      m_rr = (e_grant + 1) % NUM_REQ;
      if (bus.debug_mode_i) m_dropped++;
      else begin
        e.pc = bus.req_pc_i[g]; e.taken = bus.req_taken_i[g]; e.index = bus.req_index_i[g];
        exp_q.push_back(e);
        m_accepted++;
      end
    end
    m_done = 0;
    case (m_phase)
      0: begin m_phase = 1; m_row = 0; end
      1: begin
        if (bus.flush_i) m_row = 0;
        else if (m_row == NR_ROWS - 1) begin m_phase = 2; m_row = 0; m_done = 1; end
        else m_row++;
      end
      default: if (bus.flush_i) begin m_phase = 1; m_row = 0; exp_q.delete(); end
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_payload();
    bus.req_pc_i[0] = {$urandom, $urandom};
    bus.req_pc_i[1] = {$urandom, $urandom};
    bus.req_taken_i = 2'($urandom_range(0, 3));
    bus.req_index_i[0] = 6'($urandom);
    bus.req_index_i[1] = 6'($urandom);
  endtask

  task automatic clear_tallies();
    we_cycles = 0; upd_cycles = 0; done_pulses = 0; ready_in_flush = 0;
  endtask

  initial begin
    int acc0, drop0;
    checks = 0; errors = 0;
    clear_tallies();
    model_reset();
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.debug_mode_i = 1'b0; bus.req_valid_i = 2'b00;
    rand_payload();

    // reset hold, release, full row initialise
    for (int n = 0; n < 3; n++) cycle();
    rst = 1'b0;
    clear_tallies();
    for (int n = 0; n < 68; n++) cycle();
    chk("reset_rows", 64'(we_cycles), 64'd64);
    chk("reset_done_pulses", 64'(done_pulses), 64'd1);
    chk("reset_busy_idle", 64'(bus.busy_o), 64'd0);

    // both requesters for 4 cycles: grants alternate from requester 0
    bus.req_valid_i = 2'b11;
    for (int n = 0; n < 4; n++) begin
      rand_payload();
      cycle();
      chk("alt_grant", 64'(obs_ready), (n % 2 == 0) ? 64'd1 : 64'd2);
    end
    bus.req_valid_i = 2'b00;
    for (int n = 0; n < 3; n++) cycle();

    // five back-to-back from requester 0
    bus.req_valid_i = 2'b01;
    for (int n = 0; n < 5; n++) begin
      rand_payload();
      cycle();
      chk("b2b_ready", 64'(obs_ready), 64'd1);
    end
    bus.req_valid_i = 2'b00;
    for (int n = 0; n < 3; n++) cycle();

    // flush with entries in flight: head suppressed, 64 rows, no ready until idle
    bus.req_valid_i = 2'b01;
    for (int n = 0; n < 3; n++) begin rand_payload(); cycle(); end
    bus.req_valid_i = 2'b11;
    bus.flush_i = 1'b1;
    clear_tallies();
    cycle();
    bus.flush_i = 1'b0;
    for (int n = 0; n < 64; n++) cycle();
    chk("flush_upd_hidden", 64'(upd_cycles), 64'd0);
    chk("flush_rows", 64'(we_cycles), 64'd64);
    chk("flush_ready_low", 64'(ready_in_flush), 64'd0);
    bus.req_valid_i = 2'b00;
    for (int n = 0; n < 3; n++) cycle();

    // debug mode: two requests consumed and dropped
    acc0 = m_accepted; drop0 = m_dropped;
    bus.debug_mode_i = 1'b1;
    bus.req_valid_i = 2'b01;
    clear_tallies();
    for (int n = 0; n < 2; n++) begin
      rand_payload();
      cycle();
      chk("dbg_ready", 64'(obs_ready), 64'd1);
    end
    bus.req_valid_i = 2'b00;
    bus.debug_mode_i = 1'b0;
    for (int n = 0; n < 3; n++) cycle();
    chk("dbg_no_upd", 64'(upd_cycles), 64'd0);
    chk("dbg_model_drops", 64'(m_dropped - drop0), 64'd2);
`ifdef BHT_UPD_CTRL_STATS_EN
    chk("dbg_stat_dropped", 64'(stat_drop), 64'(drop0 + 2));
    chk("dbg_stat_accepted", 64'(stat_acc), 64'(acc0));
`else
    chk("dbg_model_accepts", 64'(m_accepted), 64'(acc0));
`endif

    // randomized traffic, debug and occasional flush
    for (int n = 0; n < 400; n++) begin
      bus.req_valid_i  = 2'($urandom_range(0, 3));
      bus.debug_mode_i = ($urandom_range(0, 7) == 0);
      bus.flush_i      = ($urandom_range(0, 63) == 0);
      rand_payload();
      cycle();
    end
    bus.req_valid_i = 2'b00; bus.debug_mode_i = 1'b0; bus.flush_i = 1'b0;

    // reset at row 30 of a flush
    for (int n = 0; n < 200 && m_phase != 2; n++) cycle();
    chk("idle_before_mid_reset", 64'(bus.init_we_o), 64'd0);
    bus.flush_i = 1'b1;
    cycle();
    bus.flush_i = 1'b0;
    for (int n = 0; n < 100 && !(m_phase == 1 && m_row == 30); n++) cycle();
    chk("row30_reached", 64'(bus.init_row_o), 64'd30);
    rst = 1'b1;
    #1;
    check_outputs();
    for (int n = 0; n < 2; n++) cycle();
    rst = 1'b0;
    cycle();
    cycle();
    chk("restart_row0", 64'(obs_row), 64'd0);
    chk("restart_we", 64'(obs_we), 64'd1);
    for (int n = 0; n < 70; n++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
